// File: rtl/regbank_pkg.sv
// Shared types and constants for the register-bank write path.
package regbank_pkg;

    localparam int REG_W    = 32;
    localparam int ADDR_W   = 2;
    localparam int NUM_REGS = 4;

    // Wide enough for MAX_BURST up to 15.
    localparam int BURST_W  = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, else wrap to the lowest.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N-1:0] upper_mask;
    logic [N-1:0] upper_req;
    logic [N-1:0] src;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign upper_mask[gi] = (IDX_W'(gi) >= ptr);
        end
    endgenerate

    assign upper_req = req & upper_mask;

    always_comb begin
        src = (|upper_req) ? upper_req : req;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (src[i]) begin
                idx = IDX_W'(i);
            end
        end
        any   = |req;
        grant = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin write-port arbiter with bounded locked bursts and a registered bank interface.
module regbank_write_arbiter #(
    parameter int NREQ      = 3,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_lock,
    input  logic [NREQ*ADDR_W-1:0]   req_dr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     write,
    output logic [ADDR_W-1:0]        dr,
    output logic [DATA_W-1:0]        write_data,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy
);

    import regbank_pkg::*;

    localparam int IDX_W = $clog2(NREQ);

    state_e             state_reg, state_next;
    logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]   holder_reg, holder_next;
    logic [BURST_W-1:0] burst_cnt_reg, burst_cnt_next;

    logic               write_reg;
    logic [ADDR_W-1:0]  dr_reg;
    logic [DATA_W-1:0]  data_reg;
    logic [IDX_W-1:0]   gid_reg;

    logic [NREQ-1:0]    arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    logic               accept;
    logic [IDX_W-1:0]   acc_idx;

    logic [ADDR_W-1:0]  dr_arr   [NREQ];
    logic [DATA_W-1:0]  data_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign dr_arr[gi]   = req_dr[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter #(
        .N     (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        holder_next    = holder_reg;
        burst_cnt_next = burst_cnt_reg;
        req_ready      = '0;
        accept         = 1'b0;
        acc_idx        = arb_idx;

        // Ready stays low while reset is asserted, even though the arbiter sees requests.
        if (rst_n) begin
            unique case (state_reg)
                IDLE: begin
                    req_ready = arb_grant;
                    if (arb_any) begin
                        accept      = 1'b1;
                        acc_idx     = arb_idx;
                        rr_ptr_next = (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + IDX_W'(1);
                        if (req_lock[arb_idx] && (MAX_BURST > 1)) begin
                            state_next     = LOCKED;
                            holder_next    = arb_idx;
                            burst_cnt_next = BURST_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    acc_idx               = holder_reg;
                    req_ready[holder_reg] = req_valid[holder_reg];
                    if (req_valid[holder_reg]) begin
                        accept = 1'b1;
                        if (!req_lock[holder_reg] ||
                            (burst_cnt_reg == BURST_W'(MAX_BURST - 1))) begin
                            state_next     = IDLE;
                            burst_cnt_next = '0;
                        end else begin
                            burst_cnt_next = burst_cnt_reg + BURST_W'(1);
                        end
                    end else if (!req_lock[holder_reg]) begin
                        state_next     = IDLE;
                        burst_cnt_next = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            holder_reg    <= '0;
            burst_cnt_reg <= '0;
            write_reg     <= 1'b0;
            dr_reg        <= '0;
            data_reg      <= '0;
            gid_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            holder_reg    <= holder_next;
            burst_cnt_reg <= burst_cnt_next;
            write_reg     <= accept;
            // Without an accept the bank-side fields keep their previous beat.
            if (accept) begin
                dr_reg   <= dr_arr[acc_idx];
                data_reg <= data_arr[acc_idx];
                gid_reg  <= acc_idx;
            end
        end
    end

    assign write      = write_reg;
    assign dr         = dr_reg;
    assign write_data = data_reg;
    assign grant_id   = gid_reg;
    assign busy       = (state_reg == LOCKED);

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Randomized and directed bench for regbank_write_arbiter against a behavioural arbitration model.
module tb_regbank_write_arbiter;

    localparam int NREQ      = 3;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 2;
    localparam int MAX_BURST = 4;
    localparam int IDX_W     = $clog2(NREQ);

    logic                    clk   = 1'b0;
    logic                    rst_n = 1'b1;
    logic [NREQ-1:0]         req_valid = '0;
    logic [NREQ-1:0]         req_lock  = '0;
    logic [NREQ*ADDR_W-1:0]  req_dr    = '0;
    logic [NREQ*DATA_W-1:0]  req_data  = '0;
    logic [NREQ-1:0]         req_ready;
    logic                    write;
    logic [ADDR_W-1:0]       dr;
    logic [DATA_W-1:0]       write_data;
    logic [IDX_W-1:0]        grant_id;
    logic                    busy;

    always #5 clk = ~clk;

    regbank_write_arbiter #(
        .NREQ      (NREQ),
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_lock   (req_lock),
        .req_dr     (req_dr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .write      (write),
        .dr         (dr),
        .write_data (write_data),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: pointer, lock holder and beat count as plain integers.
    int                m_ptr;
    int                m_holder;
    int                m_beats;
    bit                m_locked;
    bit                m_write;
    logic [ADDR_W-1:0] m_dr;
    logic [DATA_W-1:0] m_data;
    int                m_gid;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr    = 0;
        m_holder = 0;
        m_beats  = 0;
        m_locked = 0;
        m_write  = 0;
        m_dr     = '0;
        m_data   = '0;
        m_gid    = 0;
    endtask

    function automatic logic [NREQ-1:0] model_ready();
        logic [NREQ-1:0] r;
        r = '0;
        if (m_locked) begin
            r[m_holder] = req_valid[m_holder];
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (req_valid[j]) begin
                    r[j] = 1'b1;
                    break;
                end
            end
        end
        return r;
    endfunction

    task automatic set_req(input int i, input bit v, input bit l,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_valid[i]                  = v;
        req_lock[i]                   = l;
        req_dr[i*ADDR_W +: ADDR_W]    = a;
        req_data[i*DATA_W +: DATA_W]  = d;
    endtask

    // Called just after a rising edge with inputs already applied; ends just after the next edge.
    task automatic run_cycle(input string tag);
        logic [NREQ-1:0] er;
        int              j;
        #1;
        er = model_ready();
        check_val({tag, ".ready"}, 64'(req_ready), 64'(er));
        j = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (er[i]) j = i;
        end
        if (j >= 0) begin
            m_write = 1;
            m_dr    = req_dr[j*ADDR_W +: ADDR_W];
            m_data  = req_data[j*DATA_W +: DATA_W];
            m_gid   = j;
            if (!m_locked) begin
                m_ptr = (j + 1) % NREQ;
                if (req_lock[j] && MAX_BURST > 1) begin
                    m_locked = 1;
                    m_holder = j;
                    m_beats  = 1;
                end
            end else begin
                m_beats++;
                if (!req_lock[j] || m_beats == MAX_BURST) m_locked = 0;
            end
        end else begin
            m_write = 0;
            if (m_locked && !req_lock[m_holder]) m_locked = 0;
        end
        @(posedge clk);
        #1;
        check_val({tag, ".write"}, 64'(write), 64'(m_write));
        check_val({tag, ".dr"}, 64'(dr), 64'(m_dr));
        check_val({tag, ".data"}, 64'(write_data), 64'(m_data));
        check_val({tag, ".gid"}, 64'(grant_id), 64'(m_gid));
        check_val({tag, ".busy"}, 64'(busy), 64'(m_locked));
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        req_lock  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("reset.ready", 64'(req_ready), 64'(0));
        check_val("reset.write", 64'(write), 64'(0));
        check_val("reset.dr", 64'(dr), 64'(0));
        check_val("reset.data", 64'(write_data), 64'(0));
        check_val("reset.gid", 64'(grant_id), 64'(0));
        check_val("reset.busy", 64'(busy), 64'(0));
        rst_n = 1'b1;
    endtask

    int exp_gid_burst [6] = '{1, 1, 1, 1, 0, 1};

    initial begin
        logic [DATA_W-1:0] d1;

        #2;
        do_reset();
        req_valid = '1;
        run_cycle("first");
        check_val("first.gid0", 64'(grant_id), 64'(0));

        // Plain round robin, no locks.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, ADDR_W'(i), DATA_W'(32'hA0 + i));
        for (int k = 0; k < 6; k++) begin
            run_cycle("rr");
            check_val("rr.seq", 64'(grant_id), 64'(k % NREQ));
        end

        // Burst capped at MAX_BURST beats, then rr hands the port on.
        do_reset();
        req_valid = '0;
        req_lock  = '0;
        d1 = 32'h11;
        set_req(1, 1, 1, 2'd1, d1);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) set_req(0, 1, 0, 2'd0, 32'h50 + k);
            run_cycle("burst");
            check_val("burst.seq", 64'(grant_id), 64'(exp_gid_burst[k]));
            if (k < 4) check_val("burst.data", 64'(write_data), 64'(32'h11 + k));
            if (m_write && m_gid == 1) begin
                d1 = d1 + 1;
                set_req(1, 1, 1, 2'd1, d1);
            end
        end

        // Holder stalls with lock held while another requester waits.
        do_reset();
        req_valid = '0;
        req_lock  = '0;
        set_req(2, 1, 1, 2'd2, 32'hC0);
        run_cycle("stall.enter");
        set_req(0, 1, 0, 2'd0, 32'hB0);
        set_req(2, 0, 1, 2'd2, 32'hC0);
        for (int k = 0; k < 2; k++) begin
            run_cycle("stall");
            check_val("stall.write", 64'(write), 64'(0));
            check_val("stall.ready0", 64'(req_ready[0]), 64'(0));
        end
        set_req(2, 1, 0, 2'd2, 32'hC1);
        run_cycle("stall.resume");
        check_val("stall.resume_gid", 64'(grant_id), 64'(2));
        check_val("stall.resume_data", 64'(write_data), 64'(32'hC1));

        // Lock released without a beat.
        set_req(0, 0, 0, 2'd0, 32'hB0);
        set_req(2, 1, 1, 2'd3, 32'hC2);
        run_cycle("rel.enter");
        set_req(0, 1, 0, 2'd0, 32'hB1);
        set_req(2, 0, 0, 2'd3, 32'hC2);
        run_cycle("rel.drop");
        check_val("rel.busy", 64'(busy), 64'(0));
        check_val("rel.ready_now", 64'(req_ready), 64'(3'b001));
        run_cycle("rel.grant");
        check_val("rel.gid", 64'(grant_id), 64'(0));

        // Reset during a burst.
        do_reset();
        req_valid = '0;
        req_lock  = '0;
        set_req(1, 1, 1, 2'd1, 32'hD0);
        run_cycle("mid.lock");
        set_req(1, 1, 1, 2'd1, 32'hD1);
        run_cycle("mid.beat2");
        rst_n = 1'b0;
        #1;
        check_val("mid.write", 64'(write), 64'(0));
        check_val("mid.busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        check_val("mid.write_hold", 64'(write), 64'(0));
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, ADDR_W'(i), DATA_W'(32'hE0 + i));
        run_cycle("mid.restart");
        check_val("mid.restart_gid", 64'(grant_id), 64'(0));

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                        ADDR_W'($urandom), $urandom);
            end
            run_cycle("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regbank_write_arbiter.md
# regbank_write_arbiter

Arbitrates the single write port of the 4x32 register bank among NREQ independent requesters. Each requester presents a destination register and a 32-bit data word under a valid/ready handshake. The block grants one requester per cycle in round-robin order, supports bounded locked bursts, and drives the bank's write, dr and write_data through a one-cycle output register. It sits directly in front of the register bank; the read ports are not touched.

## Interface
Parameters:
- NREQ, 3, number of requesters (2..8)
- DATA_W, 32, write data width
- ADDR_W, 2, register index width (4 registers)
- MAX_BURST, 4, maximum beats accepted per lock tenure (1..15)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester write request valid
- req_lock  in  NREQ  requester asks to keep the port after this beat
- req_dr  in  NREQ*ADDR_W  packed destination index; requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NREQ*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W]
- req_ready  out  NREQ  one-hot or zero; combinational grant for this cycle
- write  out  1  registered write strobe to bank
- dr  out  ADDR_W  registered destination index to bank
- write_data  out  DATA_W  registered data to bank
- grant_id  out  $clog2(NREQ)  index of the requester whose beat is on write/dr/write_data
- busy  out  1  high while in LOCKED state

## Operation
- Accept for requester i = req_valid[i] & req_ready[i]. At most one accept per cycle.
- States: IDLE, LOCKED.
- IDLE: req_ready grants the first valid requester scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...). With no valid requesters, req_ready = 0.
- On accept of i in IDLE: rr_ptr <= (i+1) mod NREQ. If req_lock[i] = 1, go to LOCKED with holder = i and burst_cnt = 1.
- LOCKED: only the holder may receive ready. req_ready[holder] = req_valid[holder]. All other requesters see ready 0.
- Exit LOCKED to IDLE on any of the following:
  - the holder has an accepted beat with req_lock = 0 (that beat is written);
  - an accepted beat brings burst_cnt to MAX_BURST (that beat is written);
  - the holder has req_valid = 0 and req_lock = 0 in a cycle (no beat).
- Holder with req_valid = 0 and req_lock = 1: stall. No write, and the port stays reserved.
- rr_ptr does not change during LOCKED. On exit it points past the holder.
- MAX_BURST = 1: a lock request never enters LOCKED.
- Output register: on accept, the next cycle has write = 1, dr = req_dr[i], write_data = req_data[i], grant_id = i. With no accept, the next cycle has write = 0 and dr, write_data and grant_id hold their last values.
- Reset values: write = 0, dr = 0, write_data = 0, grant_id = 0, busy = 0, rr_ptr = 0, state = IDLE, burst_cnt = 0.
- Reset asserted mid-burst: lock is abandoned immediately. Any beat in the output register is dropped (write = 0). After release, arbitration restarts at requester 0.

## Timing
- Latency: accept in cycle N gives write high in cycle N+1 for exactly one cycle.
- Back-to-back accepts give continuous write = 1 with no bubbles.
- req_ready depends combinationally on req_valid, state and rr_ptr. It never depends on req_data or req_dr.
- busy rises in the cycle after the locking accept. It falls in the cycle after the exit condition.
- Throughput: one write per cycle sustained.
- Fairness: any continuously valid requester is granted within (NREQ-1)*MAX_BURST + 1 cycles of raising valid.

## Structure
- Package regbank_pkg holds:
  - REG_W = 32, ADDR_W = 2, NUM_REGS = 4;
  - the state enum (IDLE, LOCKED);
  - the burst counter width.
- Sub-module rr_arbiter provides the combinational round-robin pick. Inputs: request vector and rr_ptr. Outputs: one-hot grant and index.
- The FSM, burst counter, rr_ptr and output register live in the top module.

## Test plan
- Reset: hold rst_n = 0 with all req_valid = 1. Required: req_ready = 0, write = 0, dr = 0, write_data = 0. After release, requester 0 is granted first.
- Round-robin: NREQ = 3, all valid and never locked, data = 0xA0+i, dr = i, for 6 cycles. Required: grant_id sequence 0,1,2,0,1,2, with write high every cycle starting one cycle after the first accept.
- Burst cap: requester 1 holds lock = 1 and valid = 1 with data 0x11..0x16, requester 0 is also valid. Required: four writes from requester 1 (0x11..0x14), then one beat from requester 2 or 0 per rr order, then requester 1 resumes.
- Stall in lock: holder 2 drops valid for 2 cycles with lock = 1 while requester 0 is valid. Required: no write in those cycles and req_ready[0] = 0. Requester 2's next beat is accepted.
- Lock release without beat: holder drops both valid and lock. Required: busy falls the next cycle and the waiting requester is granted in that cycle.
- Reset mid-burst: assert rst_n = 0 on the cycle after the 2nd locked accept. Required: write = 0 in the following cycle and busy = 0. After release, rr_ptr = 0.
